// File: rtl/icache_mshr_alloc_ctrl.sv
// icache MSHR allocation controller.
// Keeps one pre-allocated entry ready so a granted miss requester gets its index
// in the same cycle. Tracks entry busy bits, takes releases from the refill path
// and reports pool occupancy.
module icache_mshr_alloc_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_W     = $clog2(ENTRY_NUM),
  parameter int REQ_NUM   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_NUM-1:0]   req_vld,
  output logic [REQ_NUM-1:0]   req_rdy,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic                 rel_vld,
  input  logic [IDX_W-1:0]     rel_idx,
  input  logic                 flush,
  output logic [IDX_W:0]       free_cnt,
  output logic                 pool_empty,
  output logic [ENTRY_NUM-1:0] busy_vec
);

  localparam int RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [ENTRY_NUM-1:0] busy_q, busy_d;
  logic                 pre_vld_q, pre_vld_d;
  logic [IDX_W-1:0]     pre_idx_q, pre_idx_d;
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

  logic [REQ_NUM-1:0]   grant_oh;
  logic [RR_W-1:0]      grant_id;
  logic                 grant_found;
  int                   cand;
  logic                 fire;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic                 rel_ok;
  logic                 preload;

  // Round-robin pick among requesters, starting at rr_ptr; nothing is granted
  // without a held entry, and flush suppresses grants in its own cycle.
  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = (int'(rr_ptr_q) + k) % REQ_NUM;
      if (!grant_found && req_vld[cand[RR_W-1:0]]) begin
        grant_found                 = 1'b1;
        grant_oh[cand[RR_W-1:0]]    = 1'b1;
        grant_id                    = cand[RR_W-1:0];
      end
    end
    if (!pre_vld_q || flush) begin
      grant_oh    = '0;
      grant_found = 1'b0;
    end
  end

  assign req_rdy = grant_oh;
  assign fire    = |(req_vld & grant_oh);

  // Lowest-index free entry, taken from the registered busy bits only so a
  // same-cycle release never feeds the pre-load search.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign rel_ok  = rel_vld && busy_q[rel_idx] && !(pre_vld_q && (rel_idx == pre_idx_q));
  assign preload = (!pre_vld_q || fire) && free_found;

  // Next-state: release, pre-load and round-robin advance; flush restores the
  // post-reset state and discards everything else happening that cycle.
  always_comb begin
    busy_d     = busy_q;
    pre_vld_d  = preload | (pre_vld_q & ~fire);
    pre_idx_d  = preload ? free_idx : pre_idx_q;
    rr_ptr_d   = fire ? RR_W'((int'(grant_id) + 1) % REQ_NUM) : rr_ptr_q;
    free_cnt_d = free_cnt_q + CNT_W'(rel_ok) - CNT_W'(preload);
    if (rel_ok) begin
      busy_d[rel_idx] = 1'b0;
    end
    if (preload) begin
      busy_d[free_idx] = 1'b1;
    end
    if (flush) begin
      busy_d     = '0;
      pre_vld_d  = 1'b0;
      pre_idx_d  = '0;
      rr_ptr_d   = '0;
      free_cnt_d = CNT_W'(ENTRY_NUM);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      pre_vld_q  <= 1'b0;
      pre_idx_q  <= '0;
      rr_ptr_q   <= '0;
      free_cnt_q <= CNT_W'(ENTRY_NUM);
    end else begin
      busy_q     <= busy_d;
      pre_vld_q  <= pre_vld_d;
      pre_idx_q  <= pre_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign alloc_idx  = pre_idx_q;
  assign free_cnt   = free_cnt_q;
  assign pool_empty = (free_cnt_q == '0) && !pre_vld_q;
  assign busy_vec   = busy_q;

  // Releasing an idle entry or the held entry indicates a refill-path bug.
  a_rel_legal: assert property (@(posedge clk) disable iff (rst || flush)
    rel_vld |-> (busy_q[rel_idx] && !(pre_vld_q && (rel_idx == pre_idx_q))));

  // The free counter must always agree with the busy bits.
  a_cnt_consistent: assert property (@(posedge clk) disable iff (rst)
    int'(free_cnt_q) == (ENTRY_NUM - $countones(busy_q)));

  // No grant may be issued without a held entry.
  a_rdy_needs_pre: assert property (@(posedge clk)
    !pre_vld_q |-> (req_rdy == '0));

endmodule
